// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues PC requests to a pipelined instruction memory,
// buffers in-order responses in a 2-entry queue and feeds a registered decode slot.
module fetch_unit #(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(32'h0000_0000)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  IMemReqA,
   output logic [DATA_WIDTH-1:0] IMemAddrA,
   input  logic                  IMemGntA,
   input  logic                  IMemRValidA,
   input  logic [31:0]           IMemRDataA,
   input  logic                  StallB,
   input  logic                  RedirectE,
   input  logic [DATA_WIDTH-1:0] RedirectPCE,
   output logic [31:0]           InstrB,
   output logic [DATA_WIDTH-1:0] PCB,
   output logic [DATA_WIDTH-1:0] PCPlus4B,
   output logic                  ValidB
);

   localparam logic [31:0]           NOP  = 32'h0000_0013;
   localparam logic [DATA_WIDTH-1:0] FOUR = DATA_WIDTH'(4);

   typedef enum logic {RUN, FLUSH} state_t;

   state_t                  state_reg, state_next;
   logic [DATA_WIDTH-1:0]   pc_reg, pc_next;
   logic [1:0]              outstanding_reg, outstanding_next;
   logic [1:0]              stale_reg, stale_next;
   logic [1:0]              q_count_reg, q_count_next;
   logic                    q_head_reg, q_head_next;
   logic [31:0]             q_instr_reg [2];
   logic [DATA_WIDTH-1:0]   q_pc_reg [2];
   logic [31:0]             instr_reg, instr_next;
   logic [DATA_WIDTH-1:0]   pcb_reg, pcb_next;
   logic [DATA_WIDTH-1:0]   pcplus4_reg, pcplus4_next;
   logic                    valid_reg, valid_next;

   logic                    grant, rsp, accept, load, pop, bypass, push;
   logic                    wr_idx;
   logic [DATA_WIDTH-1:0]   rsp_pc;

   // A response with nothing outstanding (e.g. one that straddled a reset) is ignored.
   assign grant  = IMemReqA & IMemGntA;
   assign rsp    = IMemRValidA & (outstanding_reg != 2'd0);
   // In RUN every outstanding request is live and sequential, ending at pc_reg-4.
   assign rsp_pc = pc_reg - (DATA_WIDTH'(outstanding_reg) << 2);
   assign accept = rsp & (state_reg == RUN) & ~RedirectE;
   assign load   = ~StallB & ~RedirectE;
   assign pop    = load & (q_count_reg != 2'd0);
   assign bypass = load & (q_count_reg == 2'd0) & accept;
   assign push   = accept & ~bypass;
   assign wr_idx = q_head_reg ^ q_count_reg[0];

   assign IMemReqA  = rst_n & (state_reg == RUN) & ~RedirectE &
                      (({1'b0, outstanding_reg} + {1'b0, q_count_reg}) < 3'd2);
   assign IMemAddrA = pc_reg;
   assign InstrB    = instr_reg;
   assign PCB       = pcb_reg;
   assign PCPlus4B  = pcplus4_reg;
   assign ValidB    = valid_reg;

   always_comb begin
      pc_next          = pc_reg;
      outstanding_next = outstanding_reg + {1'b0, grant} - {1'b0, rsp};
      stale_next       = stale_reg;
      q_count_next     = q_count_reg + {1'b0, push} - {1'b0, pop};
      q_head_next      = pop ? ~q_head_reg : q_head_reg;
      instr_next       = instr_reg;
      pcb_next         = pcb_reg;
      pcplus4_next     = pcplus4_reg;
      valid_next       = valid_reg;

      if (RedirectE) begin
         pc_next      = {RedirectPCE[DATA_WIDTH-1:2], 2'b00};
         stale_next   = outstanding_next;
         q_count_next = 2'd0;
         valid_next   = 1'b0;
         instr_next   = NOP;
      end else begin
         if (grant)
            pc_next = pc_reg + FOUR;
         if (state_reg == FLUSH && rsp)
            stale_next = stale_reg - 2'd1;
         if (load) begin
            if (pop) begin
               valid_next   = 1'b1;
               instr_next   = q_instr_reg[q_head_reg];
               pcb_next     = q_pc_reg[q_head_reg];
               pcplus4_next = q_pc_reg[q_head_reg] + FOUR;
            end else if (bypass) begin
               valid_next   = 1'b1;
               instr_next   = IMemRDataA;
               pcb_next     = rsp_pc;
               pcplus4_next = rsp_pc + FOUR;
            end else begin
               valid_next   = 1'b0;
               instr_next   = NOP;
            end
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         RUN:     if (RedirectE && stale_next != 2'd0) state_next = FLUSH;
         FLUSH:   if (stale_next == 2'd0)              state_next = RUN;
         default: state_next = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= RUN;
         pc_reg          <= RESET_PC;
         outstanding_reg <= 2'd0;
         stale_reg       <= 2'd0;
         q_count_reg     <= 2'd0;
         q_head_reg      <= 1'b0;
         instr_reg       <= NOP;
         pcb_reg         <= '0;
         pcplus4_reg     <= '0;
         valid_reg       <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            q_instr_reg[i] <= NOP;
            q_pc_reg[i]    <= '0;
         end
      end else begin
         state_reg       <= state_next;
         pc_reg          <= pc_next;
         outstanding_reg <= outstanding_next;
         stale_reg       <= stale_next;
         q_count_reg     <= q_count_next;
         q_head_reg      <= q_head_next;
         instr_reg       <= instr_next;
         pcb_reg         <= pcb_next;
         pcplus4_reg     <= pcplus4_next;
         valid_reg       <= valid_next;
         if (push) begin
            q_instr_reg[wr_idx] <= IMemRDataA;
            q_pc_reg[wr_idx]    <= rsp_pc;
         end
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: each task walks a scenario cycle by cycle and
// compares outputs against hand-derived values.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        IMemReqA;
   logic [31:0] IMemAddrA;
   logic        IMemGntA = 1'b0;
   logic        IMemRValidA = 1'b0;
   logic [31:0] IMemRDataA = '0;
   logic        StallB = 1'b0;
   logic        RedirectE = 1'b0;
   logic [31:0] RedirectPCE = '0;
   logic [31:0] InstrB;
   logic [31:0] PCB;
   logic [31:0] PCPlus4B;
   logic        ValidB;

   int errors = 0;
   int checks = 0;

   fetch_unit dut (
      .clk(clk), .rst_n(rst_n),
      .IMemReqA(IMemReqA), .IMemAddrA(IMemAddrA), .IMemGntA(IMemGntA),
      .IMemRValidA(IMemRValidA), .IMemRDataA(IMemRDataA),
      .StallB(StallB), .RedirectE(RedirectE), .RedirectPCE(RedirectPCE),
      .InstrB(InstrB), .PCB(PCB), .PCPlus4B(PCPlus4B), .ValidB(ValidB)
   );

   always #5 clk = ~clk;

   task automatic drive(input logic gnt, input logic rv, input logic [31:0] data,
                        input logic stall, input logic redir, input logic [31:0] rpc);
      IMemGntA    = gnt;
      IMemRValidA = rv;
      IMemRDataA  = data;
      StallB      = stall;
      RedirectE   = redir;
      RedirectPCE = rpc;
      #1;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      #12;
      checks++; if (ValidB !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", ValidB); end
      checks++; if (InstrB !== 32'h13) begin errors++; $display("FAIL rst_instr: got %h want 00000013", InstrB); end
      checks++; if (PCB !== 32'h0) begin errors++; $display("FAIL rst_pcb: got %h want 0", PCB); end
      checks++; if (PCPlus4B !== 32'h0) begin errors++; $display("FAIL rst_pcp4: got %h want 0", PCPlus4B); end
      checks++; if (IMemReqA !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", IMemReqA); end
      tick;
      rst_n = 1'b1;
      #1;
      checks++; if (IMemReqA !== 1'b1) begin errors++; $display("FAIL rel_req: got %b want 1", IMemReqA); end
      checks++; if (IMemAddrA !== 32'h0) begin errors++; $display("FAIL rel_addr: got %h want 0", IMemAddrA); end
      $display("test_reset done");
   endtask

   task automatic test_zero_wait;
      drive(1, 0, 0, 0, 0, 0); tick;
      checks++; if (ValidB !== 1'b0) begin errors++; $display("FAIL zw_v0: got %b want 0", ValidB); end
      drive(1, 1, 32'hC0DE0000, 0, 0, 0);
      checks++; if (IMemAddrA !== 32'h4) begin errors++; $display("FAIL zw_addr4: got %h want 4", IMemAddrA); end
      tick;
      checks++; if (ValidB !== 1'b1 || PCB !== 32'h0) begin errors++; $display("FAIL zw_i0: valid=%b pcb=%h want 1/0", ValidB, PCB); end
      checks++; if (InstrB !== 32'hC0DE0000) begin errors++; $display("FAIL zw_instr0: got %h want C0DE0000", InstrB); end
      checks++; if (PCPlus4B !== 32'h4) begin errors++; $display("FAIL zw_p4_0: got %h want 4", PCPlus4B); end
      drive(1, 1, 32'hC0DE0004, 0, 0, 0);
      checks++; if (IMemAddrA !== 32'h8) begin errors++; $display("FAIL zw_addr8: got %h want 8", IMemAddrA); end
      tick;
      checks++; if (ValidB !== 1'b1 || PCB !== 32'h4 || InstrB !== 32'hC0DE0004) begin errors++; $display("FAIL zw_i1: valid=%b pcb=%h instr=%h want 1/4/C0DE0004", ValidB, PCB, InstrB); end
      drive(0, 1, 32'hC0DE0008, 0, 0, 0); tick;
      checks++; if (ValidB !== 1'b1 || PCB !== 32'h8 || PCPlus4B !== 32'hC) begin errors++; $display("FAIL zw_i2: valid=%b pcb=%h p4=%h want 1/8/C", ValidB, PCB, PCPlus4B); end
      drive(0, 0, 0, 0, 0, 0); tick;
      checks++; if (ValidB !== 1'b0 || InstrB !== 32'h13 || PCB !== 32'h8) begin errors++; $display("FAIL zw_bubble: valid=%b instr=%h pcb=%h want 0/00000013/8", ValidB, InstrB, PCB); end
      $display("test_zero_wait done");
   endtask

   task automatic test_stall;
      drive(1, 0, 0, 0, 0, 0); tick;
      drive(1, 1, 32'hC0DE000C, 0, 0, 0); tick;
      drive(1, 0, 0, 1, 0, 0);
      checks++; if (IMemReqA !== 1'b1 || IMemAddrA !== 32'h14) begin errors++; $display("FAIL st_req14: req=%b addr=%h want 1/14", IMemReqA, IMemAddrA); end
      tick;
      drive(0, 1, 32'hC0DE0010, 1, 0, 0);
      checks++; if (IMemReqA !== 1'b0) begin errors++; $display("FAIL st_req_o2: got %b want 0", IMemReqA); end
      tick;
      drive(0, 1, 32'hC0DE0014, 1, 0, 0);
      checks++; if (IMemReqA !== 1'b0) begin errors++; $display("FAIL st_req_o1q1: got %b want 0", IMemReqA); end
      tick;
      drive(0, 0, 0, 1, 0, 0);
      checks++; if (IMemReqA !== 1'b0) begin errors++; $display("FAIL st_req_q2: got %b want 0", IMemReqA); end
      tick;
      checks++; if (ValidB !== 1'b1 || PCB !== 32'hC || InstrB !== 32'hC0DE000C) begin errors++; $display("FAIL st_hold: valid=%b pcb=%h instr=%h want 1/C/C0DE000C", ValidB, PCB, InstrB); end
      drive(0, 0, 0, 0, 0, 0);
      checks++; if (IMemReqA !== 1'b0) begin errors++; $display("FAIL st_req_rel: got %b want 0", IMemReqA); end
      tick;
      checks++; if (ValidB !== 1'b1 || PCB !== 32'h10 || InstrB !== 32'hC0DE0010) begin errors++; $display("FAIL st_pop0: valid=%b pcb=%h instr=%h want 1/10/C0DE0010", ValidB, PCB, InstrB); end
      drive(0, 0, 0, 0, 0, 0);
      checks++; if (IMemReqA !== 1'b1 || IMemAddrA !== 32'h18) begin errors++; $display("FAIL st_req18: req=%b addr=%h want 1/18", IMemReqA, IMemAddrA); end
      tick;
      checks++; if (ValidB !== 1'b1 || PCB !== 32'h14 || InstrB !== 32'hC0DE0014) begin errors++; $display("FAIL st_pop1: valid=%b pcb=%h instr=%h want 1/14/C0DE0014", ValidB, PCB, InstrB); end
      drive(0, 0, 0, 0, 0, 0); tick;
      checks++; if (ValidB !== 1'b0) begin errors++; $display("FAIL st_nodup: got %b want 0", ValidB); end
      $display("test_stall done");
   endtask

   task automatic test_redirect;
      drive(1, 0, 0, 0, 0, 0); tick;
      drive(1, 1, 32'hC0DE0018, 0, 0, 0); tick;
      drive(1, 0, 0, 1, 0, 0); tick;
      checks++; if (ValidB !== 1'b1 || PCB !== 32'h18) begin errors++; $display("FAIL rd_pre: valid=%b pcb=%h want 1/18", ValidB, PCB); end
      drive(0, 0, 0, 1, 1, 32'h103);
      checks++; if (IMemReqA !== 1'b0) begin errors++; $display("FAIL rd_req: got %b want 0", IMemReqA); end
      tick;
      checks++; if (ValidB !== 1'b0 || InstrB !== 32'h13) begin errors++; $display("FAIL rd_kill: valid=%b instr=%h want 0/00000013", ValidB, InstrB); end
      drive(1, 1, 32'hDEAD0001, 0, 0, 0);
      checks++; if (IMemReqA !== 1'b0) begin errors++; $display("FAIL rd_fl_req0: got %b want 0", IMemReqA); end
      tick;
      checks++; if (ValidB !== 1'b0) begin errors++; $display("FAIL rd_drop0: got %b want 0", ValidB); end
      drive(0, 1, 32'hDEAD0002, 0, 0, 0);
      checks++; if (IMemReqA !== 1'b0) begin errors++; $display("FAIL rd_fl_req1: got %b want 0", IMemReqA); end
      tick;
      checks++; if (ValidB !== 1'b0) begin errors++; $display("FAIL rd_drop1: got %b want 0", ValidB); end
      drive(1, 0, 0, 0, 0, 0);
      checks++; if (IMemReqA !== 1'b1 || IMemAddrA !== 32'h100) begin errors++; $display("FAIL rd_addr100: req=%b addr=%h want 1/100", IMemReqA, IMemAddrA); end
      tick;
      drive(0, 1, 32'hC0DE0100, 0, 0, 0); tick;
      checks++; if (ValidB !== 1'b1 || PCB !== 32'h100 || InstrB !== 32'hC0DE0100 || PCPlus4B !== 32'h104) begin errors++; $display("FAIL rd_first: valid=%b pcb=%h instr=%h p4=%h want 1/100/C0DE0100/104", ValidB, PCB, InstrB, PCPlus4B); end
      $display("test_redirect done");
   endtask

   task automatic test_redirect_grant;
      drive(1, 0, 0, 0, 0, 0); tick;
      drive(1, 0, 0, 0, 0, 0); tick;
      drive(1, 1, 32'hDEAD0003, 0, 1, 32'h200); tick;
      checks++; if (ValidB !== 1'b0) begin errors++; $display("FAIL rg_kill: got %b want 0", ValidB); end
      drive(0, 0, 0, 0, 1, 32'h300);
      checks++; if (IMemReqA !== 1'b0) begin errors++; $display("FAIL rg_req_redir2: got %b want 0", IMemReqA); end
      tick;
      drive(0, 1, 32'hDEAD0004, 0, 0, 0);
      checks++; if (IMemReqA !== 1'b0) begin errors++; $display("FAIL rg_req_flush: got %b want 0", IMemReqA); end
      tick;
      checks++; if (ValidB !== 1'b0) begin errors++; $display("FAIL rg_drop: got %b want 0", ValidB); end
      drive(1, 0, 0, 0, 0, 0);
      checks++; if (IMemReqA !== 1'b1 || IMemAddrA !== 32'h300) begin errors++; $display("FAIL rg_addr300: req=%b addr=%h want 1/300", IMemReqA, IMemAddrA); end
      tick;
      drive(0, 1, 32'hC0DE0300, 0, 0, 0); tick;
      checks++; if (ValidB !== 1'b1 || PCB !== 32'h300 || InstrB !== 32'hC0DE0300) begin errors++; $display("FAIL rg_first: valid=%b pcb=%h instr=%h want 1/300/C0DE0300", ValidB, PCB, InstrB); end
      $display("test_redirect_grant done");
   endtask

   task automatic test_wrap;
      drive(0, 0, 0, 0, 1, 32'hFFFF_FFF8); tick;
      drive(1, 0, 0, 0, 0, 0);
      checks++; if (IMemReqA !== 1'b1 || IMemAddrA !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wr_addr_f8: req=%b addr=%h want 1/FFFFFFF8", IMemReqA, IMemAddrA); end
      tick;
      drive(1, 1, 32'hC0DE_FFF8, 0, 0, 0);
      checks++; if (IMemAddrA !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_addr_fc: got %h want FFFFFFFC", IMemAddrA); end
      tick;
      checks++; if (PCB !== 32'hFFFF_FFF8 || PCPlus4B !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_i0: pcb=%h p4=%h want FFFFFFF8/FFFFFFFC", PCB, PCPlus4B); end
      drive(0, 1, 32'hC0DE_FFFC, 0, 0, 0);
      checks++; if (IMemReqA !== 1'b1 || IMemAddrA !== 32'h0) begin errors++; $display("FAIL wr_addr0: req=%b addr=%h want 1/0", IMemReqA, IMemAddrA); end
      tick;
      checks++; if (ValidB !== 1'b1 || PCB !== 32'hFFFF_FFFC || PCPlus4B !== 32'h0 || InstrB !== 32'hC0DE_FFFC) begin errors++; $display("FAIL wr_i1: valid=%b pcb=%h p4=%h instr=%h want 1/FFFFFFFC/0/C0DEFFFC", ValidB, PCB, PCPlus4B, InstrB); end
      $display("test_wrap done");
   endtask

   task automatic test_reset_mid;
      drive(0, 0, 0, 0, 1, 32'h40); tick;
      drive(1, 0, 0, 0, 0, 0); tick;
      drive(1, 1, 32'hC0DE0040, 0, 0, 0); tick;
      drive(1, 0, 0, 1, 0, 0); tick;
      drive(0, 1, 32'hC0DE0044, 1, 0, 0); tick;
      checks++; if (ValidB !== 1'b1 || PCB !== 32'h40) begin errors++; $display("FAIL rm_pre: valid=%b pcb=%h want 1/40", ValidB, PCB); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (ValidB !== 1'b0 || InstrB !== 32'h13) begin errors++; $display("FAIL rm_out: valid=%b instr=%h want 0/00000013", ValidB, InstrB); end
      checks++; if (PCB !== 32'h0 || PCPlus4B !== 32'h0) begin errors++; $display("FAIL rm_pc: pcb=%h p4=%h want 0/0", PCB, PCPlus4B); end
      checks++; if (IMemReqA !== 1'b0) begin errors++; $display("FAIL rm_req: got %b want 0", IMemReqA); end
      drive(0, 1, 32'hC0DE0048, 0, 0, 0);
      tick; tick;
      rst_n = 1'b1;
      drive(1, 1, 32'hDEAD0005, 0, 0, 0);
      checks++; if (IMemReqA !== 1'b1 || IMemAddrA !== 32'h0) begin errors++; $display("FAIL rm_resume: req=%b addr=%h want 1/0", IMemReqA, IMemAddrA); end
      tick;
      checks++; if (ValidB !== 1'b0) begin errors++; $display("FAIL rm_late: got %b want 0", ValidB); end
      drive(0, 1, 32'hC0DE0000, 0, 0, 0); tick;
      checks++; if (ValidB !== 1'b1 || PCB !== 32'h0 || InstrB !== 32'hC0DE0000) begin errors++; $display("FAIL rm_first: valid=%b pcb=%h instr=%h want 1/0/C0DE0000", ValidB, PCB, InstrB); end
      $display("test_reset_mid done");
   endtask

   initial begin
      test_reset;
      test_zero_wait;
      test_stall;
      test_redirect;
      test_redirect_grant;
      test_wrap;
      test_reset_mid;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
